// File: rtl/uart_reg_decoder.sv
// Parses UART bytes into 4-byte register-write frames (5 with UART_REG_CHECKSUM_EN)
// with header resync, inter-byte timeout and frame error reporting.
module uart_reg_decoder #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int CNT_W          = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        reg_ready,
   output logic [6:0]  reg_address,
   output logic [15:0] reg_data,
   output logic        frame_err,
   output logic        busy
);

`ifdef UART_REG_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, GOT0, GOT1, GOT2, CHK} state_t;
`else
   typedef enum logic [1:0] {IDLE, GOT0, GOT1, GOT2} state_t;
`endif

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [6:0]       addr_q;
   logic [1:0]       data_hi;
   logic [6:0]       data_mid;
`ifdef UART_REG_CHECKSUM_EN
   logic [6:0]       data_lo;
   logic [6:0]       csum_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         addr_q      <= '0;
         data_hi     <= '0;
         data_mid    <= '0;
`ifdef UART_REG_CHECKSUM_EN
         data_lo     <= '0;
         csum_q      <= '0;
`endif
         reg_ready   <= 1'b0;
         reg_address <= '0;
         reg_data    <= '0;
         frame_err   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         reg_ready <= 1'b0;
         frame_err <= 1'b0;
         if (rx_valid) begin
            // A received byte always wins over a coincident timeout.
            cnt <= '0;
            if (rx_data[7]) begin
               if (state != IDLE) frame_err <= 1'b1;
               addr_q <= rx_data[6:0];
`ifdef UART_REG_CHECKSUM_EN
               csum_q <= rx_data[6:0];
`endif
               state  <= GOT0;
               busy   <= 1'b1;
            end else begin
               case (state)
                  IDLE: ;
                  GOT0: begin
                     data_hi <= rx_data[1:0];
`ifdef UART_REG_CHECKSUM_EN
                     csum_q  <= csum_q ^ rx_data[6:0];
`endif
                     state   <= GOT1;
                  end
                  GOT1: begin
                     data_mid <= rx_data[6:0];
`ifdef UART_REG_CHECKSUM_EN
                     csum_q   <= csum_q ^ rx_data[6:0];
`endif
                     state    <= GOT2;
                  end
`ifdef UART_REG_CHECKSUM_EN
                  GOT2: begin
                     data_lo <= rx_data[6:0];
                     csum_q  <= csum_q ^ rx_data[6:0];
                     state   <= CHK;
                  end
                  CHK: begin
                     if (rx_data[6:0] == csum_q) begin
                        reg_address <= addr_q;
                        reg_data    <= {data_hi, data_mid, data_lo};
                        reg_ready   <= 1'b1;
                     end else begin
                        frame_err   <= 1'b1;
                     end
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
`else
                  GOT2: begin
                     reg_address <= addr_q;
                     reg_data    <= {data_hi, data_mid, rx_data[6:0]};
                     reg_ready   <= 1'b1;
                     state       <= IDLE;
                     busy        <= 1'b0;
                  end
`endif
                  default: begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               endcase
            end
         end else if (state != IDLE) begin
            if (cnt == TO_LAST) begin
               frame_err <= 1'b1;
               state     <= IDLE;
               busy      <= 1'b0;
               cnt       <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/uart_reg_decoder.md
Name: uart_reg_decoder

Overview:
- Sits directly upstream of the register-write logic and downstream of the UART receiver.
- Parses received bytes into register-write frames and emits one registered write (`reg_ready`, `reg_address`, `reg_data`).
- Those outputs feed the DAC channel registers (address 0x7F) and the ADC enable (address 0x7E).
- Provides frame resynchronisation, inter-byte timeout and error reporting.

Parameters:
- `TIMEOUT_CYCLES`, default 50000: clk cycles allowed between bytes of one frame (2 ms at 25 MHz) before the frame is aborted.
- `CNT_W`, default 16: width of the timeout counter; must satisfy 2^`CNT_W` > `TIMEOUT_CYCLES`.

Ports:
- `clk` input 1: system clock (`SYS_CLK` domain, 25 MHz).
- `rst` input 1: synchronous reset, active-high.
- `rx_data` input 8: received byte from UART, valid when `rx_valid`=1.
- `rx_valid` input 1: one-cycle strobe per received byte.
- `reg_ready` output 1: one-cycle pulse, register write available.
- `reg_address` output 7: register address, held until the next write.
- `reg_data` output 16: register data, held until the next write.
- `frame_err` output 1: one-cycle pulse on an aborted or malformed frame.
- `busy` output 1: high while a frame is partially received.

Behaviour:
- Clock and reset: one clock (`clk`); reset is synchronous and active-high (`rst`).
- Reset values:
  - `reg_ready`=0, `reg_address`=0, `reg_data`=0, `frame_err`=0, `busy`=0.
  - State=IDLE, timeout counter=0, shift registers=0.
- Frame format, 4 bytes:
  - B0 = {1, addr[6:0]} (header; MSB=1 marks the header).
  - B1 = {0, 5'bx, data[15:14]}; bits [6:2] are ignored.
  - B2 = {0, data[13:7]}.
  - B3 = {0, data[6:0]}.
- States: IDLE, GOT0, GOT1, GOT2; plus CHK when `UART_REG_CHECKSUM_EN` is defined.
- IDLE:
  - `rx_valid` with MSB=1: latch addr, go to GOT0.
  - `rx_valid` with MSB=0: discard silently; no `frame_err`.
- GOTn:
  - `rx_valid` with MSB=0: latch payload bits and advance.
  - Last data byte: in the same edge, update `reg_address`/`reg_data` and pulse `reg_ready` the following cycle (latency 1 clk after the B3 strobe); return to IDLE.
- Header mid-frame (MSB=1 while in GOT0..GOT2/CHK):
  - Pulse `frame_err`.
  - Restart the frame with the new address, going to GOT0, in the same cycle.
  - The partial frame is never written.
- Timeout:
  - The counter clears on every `rx_valid` and increments each clk while state≠IDLE.
  - On reaching `TIMEOUT_CYCLES`: pulse `frame_err`, go to IDLE, clear the counter.
  - If `rx_valid` coincides with the timeout cycle, the byte wins: no timeout, the byte is processed.
- Outputs:
  - `reg_address`/`reg_data` change only on a completed frame.
  - `reg_ready` and `frame_err` are never high together. When a frame completes, `frame_err` is not asserted.
  - `busy` = (state≠IDLE), registered.
- Back-to-back frames:
  - A header arriving the cycle after B3 is accepted.
  - `reg_ready` still pulses exactly once for the previous frame.
- `rst` mid-frame: abort with no `reg_ready` and no `frame_err`; all outputs return to reset values the next cycle.
- `rx_valid` held high for multiple cycles: each cycle counts as a new byte. Upstream guarantees single-cycle strobes.

Optional Feature:
- Macro: `UART_REG_CHECKSUM_EN`.
- With the macro defined:
  - A fifth byte B4 = {0, (B0^B1^B2^B3)[6:0]} follows B3; state CHK waits for it.
  - If B4 matches: write outputs and pulse `reg_ready` 1 clk after the B4 strobe.
  - If B4 mismatches: pulse `frame_err`, no write, go to IDLE.
  - A header byte in CHK follows the mid-frame resync rule.
- Without the macro: 4-byte frames, no CHK state, write on B3.

Test Plan:
- Reset, then bytes 0xFF,0x00,0x18,0x10 (checksum off) → one `reg_ready` pulse 1 clk after the last strobe; `reg_address`=0x7F, `reg_data`=0x0C10; `frame_err` never high.
- Bytes 0xFE,0x00,0x00,0x01 then 0xFF,0x03,0x7F,0x7F back-to-back → two pulses: (0x7E, 0x0001), then (0x7F, 0xFFFF).
- Bytes 0xFF,0x00 then 0xFE,0x00,0x00,0x00 → `frame_err` pulse at the 0xFE strobe; single `reg_ready` with (0x7E, 0x0000); 0x7F is never written.
- Bytes 0xFF,0x00, then idle `TIMEOUT_CYCLES` clks → `frame_err` pulse, `busy`=0, outputs unchanged. Repeat with a byte strobed exactly on the timeout cycle → no `frame_err`.
- Stray 0x05,0x12 in IDLE → no pulses, `busy`=0. `rst` asserted after 0xFF,0x00,0x18 → no `reg_ready`; B3 0x10 afterwards is ignored.
- `UART_REG_CHECKSUM_EN` defined:
  - 0xFF,0x00,0x18,0x10,0x77 → (0x7F, 0x0C10).
  - Same frame with last byte 0x76 → `frame_err`, no write.
